ex_sequencer: RTL and testbench

- Multi-cycle controller for the execution stage of the single-cycle core.
- Accepts one operation per handshake. Base ALU ops go to the combinational ALU (ALU_op driven through) and the result is registered.
- RV32M MUL/DIV ops run on an internal iterative shift-add / restoring-divide datapath.
- Asserts stall so PC/fetch hold while a multi-cycle op is in flight.

---
 rtl/ex_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_ex_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ex_sequencer.sv
// ex_sequencer: execute-stage controller. Base ALU ops complete in one cycle
// through the external combinational ALU. RV32M ops run on a shared iterative
// datapath: shift-add for multiply, restoring division for divide/remainder.
// Operands are reduced to magnitudes at accept and the sign is fixed up at the end.
// BITS_PER_CYCLE must be 1, 2 or 4 and must divide XLEN.
module ex_sequencer #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic            is_muldiv,
  input  logic [2:0]      funct3,
  input  logic [2:0]      alu_op_in,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic [2:0]      ALU_op,
  input  logic [XLEN-1:0] alu_res,
  output logic [XLEN-1:0] res,
  output logic            zero,
  output logic            res_valid,
  output logic            stall
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0]   LAST = CW'(N - 1);
  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ITER_MUL, ITER_DIV, FIX, DONE} state_t;

  state_t            state;
  logic [2:0]        fn;
  logic [XLEN-1:0]   opb;      // |op2|: multiplicand or divisor
  logic [2*XLEN-1:0] acc;      // mul: {hi, multiplier/lo}; div: {remainder, quotient}
  logic [CW-1:0]     cnt;
  logic              qneg, rneg;

  logic              accept;
  logic              s1, s2, neg1, neg2, by_zero, ovf;
  logic [XLEN-1:0]   mag1, mag2;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  assign ALU_op      = alu_op_in;
  assign issue_ready = (state == IDLE) || (state == DONE);
  assign accept      = issue_valid && issue_ready;
  assign stall       = (state == ITER_MUL) || (state == ITER_DIV) || (state == FIX) ||
                       (accept && is_muldiv);

  // Operand signedness, magnitudes and division special cases for the presented op.
  always_comb begin
    s1      = !funct3[2] ? (funct3[1:0] != 2'b11) : !funct3[0];
    s2      = !funct3[2] ? !funct3[1]             : !funct3[0];
    neg1    = s1 && op1[XLEN-1];
    neg2    = s2 && op2[XLEN-1];
    mag1    = neg1 ? -op1 : op1;
    mag2    = neg2 ? -op2 : op2;
    by_zero = (op2 == '0);
    ovf     = !funct3[0] && (op1 == MIN) && (op2 == {XLEN{1'b1}});
  end

  // One multiply iteration: BITS_PER_CYCLE conditional adds with right shifts.
  always_comb begin
    logic [2*XLEN:0] m;
    m = {1'b0, acc};
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (m[0]) m[2*XLEN:XLEN] = m[2*XLEN:XLEN] + {1'b0, opb};
      m = m >> 1;
    end
    mul_nxt = m[2*XLEN-1:0];
  end

  // One restoring-division iteration: BITS_PER_CYCLE quotient bits.
  always_comb begin
    logic [XLEN:0]   rx;
    logic [XLEN-1:0] r, q;
    r = acc[2*XLEN-1:XLEN];
    q = acc[XLEN-1:0];
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      rx = {r, q[XLEN-1]};
      q  = q << 1;
      if (rx >= {1'b0, opb}) begin
        rx   = rx - {1'b0, opb};
        q[0] = 1'b1;
      end
      r = rx[XLEN-1:0];
    end
    div_nxt = {r, q};
  end

  // Sign fix-up and result selection from the finished accumulator.
  always_comb begin
    prod = qneg ? -acc : acc;
    quo  = qneg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = rneg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (fn)
      3'b000:                 fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo;
      default:                fix_res = rem;
    endcase
  end

  // Controller FSM with registered result, zero flag and result pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      res       <= '0;
      zero      <= 1'b1;
      res_valid <= 1'b0;
      fn        <= '0;
      opb       <= '0;
      acc       <= '0;
      cnt       <= '0;
      qneg      <= 1'b0;
      rneg      <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (accept) begin
            if (!is_muldiv) begin
              res       <= alu_res;
              zero      <= (alu_res == '0);
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              fn   <= funct3;
              opb  <= mag2;
              qneg <= neg1 ^ neg2;
              rneg <= neg1;
              cnt  <= '0;
              if (!funct3[2]) begin
                acc   <= {{XLEN{1'b0}}, mag1};
                state <= ITER_MUL;
              end else if (by_zero) begin
                // quotient all ones, remainder is the raw dividend
                acc   <= {op1, {XLEN{1'b1}}};
                qneg  <= 1'b0;
                rneg  <= 1'b0;
                state <= FIX;
              end else if (ovf) begin
                // MIN / -1: quotient MIN, remainder 0
                acc   <= {{XLEN{1'b0}}, MIN};
                qneg  <= 1'b0;
                rneg  <= 1'b0;
                state <= FIX;
              end else begin
                acc   <= {{XLEN{1'b0}}, mag1};
                state <= ITER_DIV;
              end
            end
          end
        end
        ITER_MUL: begin
          acc <= mul_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        ITER_DIV: begin
          acc <= div_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          res       <= fix_res;
          zero      <= (fix_res == '0);
          res_valid <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_sequencer.sv
// Bench for ex_sequencer: directed spec cases, back-to-back, reset abort and
// randomized ops against a 64-bit arithmetic reference model.
module tb_ex_sequencer;

  localparam int XLEN = 32;
  localparam int BPC  = 1;
  localparam int N    = XLEN / BPC;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid, issue_ready, is_muldiv;
  logic [2:0]      funct3, alu_op_in, ALU_op;
  logic [XLEN-1:0] op1, op2, alu_res, res;
  logic            zero, res_valid, stall;

  int checks = 0;
  int errors = 0;

  ex_sequencer #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .is_muldiv(is_muldiv), .funct3(funct3), .alu_op_in(alu_op_in), .op1(op1),
    .op2(op2), .ALU_op(ALU_op), .alu_res(alu_res), .res(res), .zero(zero),
    .res_valid(res_valid), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference RV32M semantics from wide signed/unsigned arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int ref_lat(input bit md, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!md) return 1;
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
    return N + 2;
  endfunction

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op from IDLE, then check latency, stall, result and pulse width.
  task automatic run_op(input bit md, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    logic [31:0] stub, exp;
    int el, lat, stl;
    stub = $urandom;
    exp  = md ? ref_md(f, a, b) : stub;
    el   = ref_lat(md, f, a, b);
    issue_valid = 1'b1; is_muldiv = md; funct3 = f; op1 = a; op2 = b;
    alu_op_in = 3'($urandom); alu_res = stub;
    #1;
    chk({tag, " ready"}, 64'(issue_ready), 64'(1));
    chk({tag, " alu_op"}, 64'(ALU_op), 64'(alu_op_in));
    chk({tag, " stall_T"}, 64'(stall), 64'(md));
    @(posedge clk); #1;
    issue_valid = 1'b0; op1 = $urandom; op2 = $urandom; alu_res = $urandom;
    lat = 1; stl = 0;
    while (!res_valid && lat < 200) begin
      if (stall) stl++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(el));
    chk({tag, " stall_cycles"}, 64'(stl), 64'(el - 1));
    chk({tag, " res"}, 64'(res), 64'(exp));
    chk({tag, " zero"}, 64'(zero), 64'(exp == 0));
    @(posedge clk); #1;
    chk({tag, " pulse"}, 64'(res_valid), 64'(0));
    chk({tag, " hold"}, 64'(res), 64'(exp));
  endtask

  initial begin
    logic [31:0] stub2;
    int lat, seen;
    rst = 1'b1; issue_valid = 1'b0; is_muldiv = 1'b0; funct3 = '0;
    alu_op_in = '0; op1 = '0; op2 = '0; alu_res = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst res", 64'(res), 64'(0));
    chk("rst zero", 64'(zero), 64'(1));
    chk("rst res_valid", 64'(res_valid), 64'(0));
    chk("rst stall", 64'(stall), 64'(0));
    chk("rst ready", 64'(issue_ready), 64'(1));
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_op(0, 3'd0, 32'h0, 32'h0, "alu");
    run_op(1, 3'd0, 32'hFFFF_FFFE, 32'd3, "mul");
    run_op(1, 3'd1, 32'hFFFF_FFFE, 32'd3, "mulh");
    run_op(1, 3'd3, 32'hFFFF_FFFE, 32'd3, "mulhu");
    run_op(1, 3'd2, 32'hFFFF_FFFE, 32'd3, "mulhsu");
    run_op(1, 3'd4, 32'hFFFF_FFF9, 32'd2, "div");
    run_op(1, 3'd6, 32'hFFFF_FFF9, 32'd2, "rem");
    run_op(1, 3'd5, 32'd7, 32'd2, "divu");
    run_op(1, 3'd4, 32'd5, 32'd0, "div0");
    run_op(1, 3'd7, 32'd5, 32'd0, "remu0");
    run_op(1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

    // Explicit ALU case from the plan: ALU_op follows alu_op_in, result 0xC
    issue_valid = 1'b1; is_muldiv = 1'b0; alu_op_in = 3'b000; alu_res = 32'hC;
    #1;
    chk("alu_c alu_op", 64'(ALU_op), 64'(3'b000));
    @(posedge clk); #1;
    issue_valid = 1'b0;
    chk("alu_c res_valid", 64'(res_valid), 64'(1));
    chk("alu_c res", 64'(res), 64'(32'hC));
    chk("alu_c zero", 64'(zero), 64'(0));
    @(posedge clk); #1;

    // Back-to-back: ALU op accepted in the DONE cycle of a DIV
    issue_valid = 1'b1; is_muldiv = 1'b1; funct3 = 3'd4; op1 = 32'hFFFF_FFEC; op2 = 32'd3;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("b2b div latency", 64'(lat), 64'(N + 2));
    chk("b2b div res", 64'(res), 64'(32'hFFFF_FFFA));
    stub2 = $urandom | 32'h1;
    issue_valid = 1'b1; is_muldiv = 1'b0; alu_res = stub2;
    #1;
    chk("b2b ready_done", 64'(issue_ready), 64'(1));
    @(posedge clk); #1;
    issue_valid = 1'b0;
    chk("b2b alu res_valid", 64'(res_valid), 64'(1));
    chk("b2b alu res", 64'(res), 64'(stub2));
    @(posedge clk); #1;
    chk("b2b pulse end", 64'(res_valid), 64'(0));

    // Reset during a MUL abandons it
    issue_valid = 1'b1; is_muldiv = 1'b1; funct3 = 3'd0; op1 = 32'd1234; op2 = 32'd5678;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort busy", 64'(stall), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort res", 64'(res), 64'(0));
    chk("abort zero", 64'(zero), 64'(1));
    chk("abort res_valid", 64'(res_valid), 64'(0));
    chk("abort stall", 64'(stall), 64'(0));
    chk("abort ready", 64'(issue_ready), 64'(1));
    seen = 0;
    repeat (N + 8) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    chk("abort no pulse", 64'(seen), 64'(0));

    // Randomized ops
    for (int k = 0; k < 40; k++) begin
      bit md;
      md = ($urandom_range(0, 9) < 7);
      run_op(md, 3'($urandom), pick_opnd(), pick_opnd(), $sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
